// File: rtl/xpu_vpu_pc_tn_vlsu_dcq_array.sv
// rtl/xpu_vpu_pc_tn_vlsu_dcq_array.sv - in-order data-completion queue for vector loads
module xpu_vpu_pc_tn_vlsu_dcq_array #(
    parameter  int DEPTH = 8,
    parameter  int UID_W = 8,
    parameter  int ENUM  = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             dcq_entry_clk,
    input  logic             cpurst_b,
    input  logic             giu_xx_async_flush,
    input  logic             crt_vld,
    output logic             crt_rdy,
    input  logic [UID_W-1:0] crt_uid,
    input  logic [ENUM-1:0]  crt_vmask,
    input  logic             crt_no_wb,
    input  logic [4:0]       crt_vdreg0_idx,
    input  logic             crt_op_last,
    output logic [PTR_W-1:0] crt_idx,
    input  logic             dret_vld,
    input  logic [PTR_W-1:0] dret_idx,
    input  logic [ENUM-1:0]  dret_mask,
    output logic             rtr_vld,
    input  logic             rtr_rdy,
    output logic [UID_W-1:0] rtr_uid,
    output logic [4:0]       rtr_vdreg0_idx,
    output logic             rtr_wb_vld,
    output logic             rtr_op_last,
    output logic [PTR_W:0]   dcq_cnt,
    output logic             dcq_empty
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0] ent_vld;
    logic [DEPTH-1:0] ent_wb_vld;
    logic [DEPTH-1:0] ent_last;
    logic [ENUM-1:0]  ent_pend [DEPTH];
    logic [UID_W-1:0] ent_uid  [DEPTH];
    logic [4:0]       ent_vd   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   cnt;

    logic crt_fire;
    logic rtr_fire;
    logic dret_hit;
    logic head_cmpl;

    assign crt_rdy   = (cnt < DEPTH_CNT) & ~giu_xx_async_flush;
    assign crt_fire  = crt_vld & crt_rdy;
    assign head_cmpl = ent_vld[head] & ~(|ent_pend[head]);
    assign rtr_vld   = head_cmpl & ~giu_xx_async_flush;
    assign rtr_fire  = rtr_vld & rtr_rdy;
    assign dret_hit  = dret_vld & ent_vld[dret_idx];

    assign crt_idx        = tail;
    assign rtr_uid        = ent_uid[head];
    assign rtr_vdreg0_idx = ent_vd[head];
    assign rtr_wb_vld     = ent_wb_vld[head];
    assign rtr_op_last    = ent_last[head];
    assign dcq_cnt        = cnt;
    assign dcq_empty      = (cnt == '0);

    // Control state: flush dominates every same-cycle event.
    always_ff @(posedge dcq_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ent_vld    <= '0;
            ent_wb_vld <= '0;
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
        end else if (giu_xx_async_flush) begin
            ent_vld    <= '0;
            ent_wb_vld <= '0;
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
        end else begin
            if (rtr_fire) begin
                ent_vld[head]    <= 1'b0;
                ent_wb_vld[head] <= 1'b0;
                head             <= head + 1'b1;
            end
            if (crt_fire) begin
                ent_vld[tail]    <= 1'b1;
                ent_wb_vld[tail] <= ~crt_no_wb;
                tail             <= tail + 1'b1;
            end
            case ({crt_fire, rtr_fire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload and pending masks are qualified by ent_vld, so they need no reset.
    always_ff @(posedge dcq_entry_clk) begin
        if (dret_hit) begin
            ent_pend[dret_idx] <= ent_pend[dret_idx] & ~dret_mask;
        end
        if (crt_fire) begin
            ent_pend[tail] <= crt_vmask;
            ent_uid[tail]  <= crt_uid;
            ent_vd[tail]   <= crt_vdreg0_idx;
            ent_last[tail] <= crt_op_last;
        end
    end

endmodule

// File: tb/tb_xpu_vpu_pc_tn_vlsu_dcq_array.sv
// tb/tb_xpu_vpu_pc_tn_vlsu_dcq_array.sv - vector table, corner sequences and random model check
module tb_xpu_vpu_pc_tn_vlsu_dcq_array;

    logic        clk = 1'b0;
    logic        cpurst_b;
    logic        flush;
    logic        crt_vld, crt_rdy, crt_no_wb, crt_op_last;
    logic [7:0]  crt_uid;
    logic [15:0] crt_vmask;
    logic [4:0]  crt_vdreg0_idx;
    logic [2:0]  crt_idx;
    logic        dret_vld;
    logic [2:0]  dret_idx;
    logic [15:0] dret_mask;
    logic        rtr_vld, rtr_rdy, rtr_wb_vld, rtr_op_last;
    logic [7:0]  rtr_uid;
    logic [4:0]  rtr_vdreg0_idx;
    logic [3:0]  dcq_cnt;
    logic        dcq_empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xpu_vpu_pc_tn_vlsu_dcq_array #(.DEPTH(8), .UID_W(8), .ENUM(16)) dut (
        .dcq_entry_clk      (clk),
        .cpurst_b           (cpurst_b),
        .giu_xx_async_flush (flush),
        .crt_vld            (crt_vld),
        .crt_rdy            (crt_rdy),
        .crt_uid            (crt_uid),
        .crt_vmask          (crt_vmask),
        .crt_no_wb          (crt_no_wb),
        .crt_vdreg0_idx     (crt_vdreg0_idx),
        .crt_op_last        (crt_op_last),
        .crt_idx            (crt_idx),
        .dret_vld           (dret_vld),
        .dret_idx           (dret_idx),
        .dret_mask          (dret_mask),
        .rtr_vld            (rtr_vld),
        .rtr_rdy            (rtr_rdy),
        .rtr_uid            (rtr_uid),
        .rtr_vdreg0_idx     (rtr_vdreg0_idx),
        .rtr_wb_vld         (rtr_wb_vld),
        .rtr_op_last        (rtr_op_last),
        .dcq_cnt            (dcq_cnt),
        .dcq_empty          (dcq_empty)
    );

    typedef struct {
        logic        cv;
        logic [7:0]  uid;
        logic [15:0] vm;
        logic        nwb;
        logic        dv;
        logic [2:0]  di;
        logic [15:0] dm;
        logic        rr;
        logic        fl;
        logic        e_rdy;
        logic [2:0]  e_idx;
        logic        e_rtr;
        logic [3:0]  e_cnt;
        logic [7:0]  e_uid;
        logic        e_wb;
    } vec_t;

    typedef struct {
        logic [7:0]  uid;
        logic [4:0]  vd;
        logic        wb;
        logic        last;
        logic [15:0] pend;
        logic [2:0]  slot;
    } ent_t;

    ent_t q[$];
    int   mtail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic cv, input logic [7:0] uid, input logic [15:0] vm, input logic nwb,
                         input logic dv, input logic [2:0] di, input logic [15:0] dm,
                         input logic rr, input logic fl);
        crt_vld        = cv;
        crt_uid        = uid;
        crt_vmask      = vm;
        crt_no_wb      = nwb;
        crt_vdreg0_idx = uid[4:0];
        crt_op_last    = uid[0];
        dret_vld       = dv;
        dret_idx       = di;
        dret_mask      = dm;
        rtr_rdy        = rr;
        flush          = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cpurst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cpurst_b = 1'b1;
        q.delete();
        mtail = 0;
    endtask

    task automatic create_n(input int n, input logic [7:0] base, input logic [15:0] vm);
        for (int i = 0; i < n; i++) begin
            drive(1, base + 8'(i), vm, 0, 0, 0, 0, 0, 0);
            tick;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{0,8'h00,16'h0000,0, 0,0,16'h0000, 0,0, 1,0,0,0,8'h00,0};
        tbl[1]  = '{1,8'h11,16'h000F,0, 0,0,16'h0000, 0,0, 1,0,0,0,8'h00,0};
        tbl[2]  = '{0,8'h00,16'h0000,0, 1,0,16'h0003, 0,0, 1,1,0,1,8'h00,0};
        tbl[3]  = '{0,8'h00,16'h0000,0, 1,0,16'h000C, 0,0, 1,1,0,1,8'h00,0};
        tbl[4]  = '{0,8'h00,16'h0000,0, 0,0,16'h0000, 0,0, 1,1,1,1,8'h11,1};
        tbl[5]  = '{0,8'h00,16'h0000,0, 0,0,16'h0000, 1,0, 1,1,1,1,8'h11,1};
        tbl[6]  = '{0,8'h00,16'h0000,0, 0,0,16'h0000, 0,0, 1,1,0,0,8'h00,0};
        tbl[7]  = '{1,8'h20,16'h0001,0, 0,0,16'h0000, 0,0, 1,1,0,0,8'h00,0};
        tbl[8]  = '{1,8'h21,16'h0001,0, 0,0,16'h0000, 0,0, 1,2,0,1,8'h00,0};
        tbl[9]  = '{0,8'h00,16'h0000,0, 1,2,16'h0001, 1,0, 1,3,0,2,8'h00,0};
        tbl[10] = '{0,8'h00,16'h0000,0, 0,0,16'h0000, 1,0, 1,3,0,2,8'h00,0};
        tbl[11] = '{0,8'h00,16'h0000,0, 1,1,16'h0001, 1,0, 1,3,0,2,8'h00,0};
        tbl[12] = '{0,8'h00,16'h0000,0, 0,0,16'h0000, 1,0, 1,3,1,2,8'h20,1};
        tbl[13] = '{0,8'h00,16'h0000,0, 0,0,16'h0000, 1,0, 1,3,1,1,8'h21,1};
        tbl[14] = '{0,8'h00,16'h0000,0, 0,0,16'h0000, 0,0, 1,3,0,0,8'h00,0};
        tbl[15] = '{1,8'h30,16'h0000,1, 0,0,16'h0000, 0,0, 1,3,0,0,8'h00,0};
        tbl[16] = '{0,8'h00,16'h0000,0, 0,0,16'h0000, 0,0, 1,4,1,1,8'h30,0};
        tbl[17] = '{0,8'h00,16'h0000,0, 1,6,16'hFFFF, 1,0, 1,4,1,1,8'h30,0};
        tbl[18] = '{0,8'h00,16'h0000,0, 0,0,16'h0000, 0,0, 1,4,0,0,8'h00,0};

        do_reset;
        @(negedge clk);
        chk("rst_crt_rdy", crt_rdy, 1);
        chk("rst_empty", dcq_empty, 1);
        tick;

        for (int r = 0; r < 19; r++) begin
            drive(tbl[r].cv, tbl[r].uid, tbl[r].vm, tbl[r].nwb, tbl[r].dv, tbl[r].di,
                  tbl[r].dm, tbl[r].rr, tbl[r].fl);
            @(negedge clk);
            chk($sformatf("tbl%0d_crt_rdy", r), crt_rdy, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_crt_idx", r), crt_idx, tbl[r].e_idx);
            chk($sformatf("tbl%0d_rtr_vld", r), rtr_vld, tbl[r].e_rtr);
            chk($sformatf("tbl%0d_cnt", r), dcq_cnt, tbl[r].e_cnt);
            chk($sformatf("tbl%0d_empty", r), dcq_empty, tbl[r].e_cnt == 0);
            if (tbl[r].e_rtr) begin
                chk($sformatf("tbl%0d_uid", r), rtr_uid, tbl[r].e_uid);
                chk($sformatf("tbl%0d_wb", r), rtr_wb_vld, tbl[r].e_wb);
            end
            tick;
        end

        // Full queue, dropped create, wrap of the tail pointer
        do_reset;
        create_n(8, 8'h40, 16'h0000);
        @(negedge clk);
        chk("full_cnt", dcq_cnt, 8);
        chk("full_crt_rdy", crt_rdy, 0);
        chk("full_rtr_vld", rtr_vld, 1);
        drive(1, 8'h99, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("full_drop_rdy", crt_rdy, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("full_drop_cnt", dcq_cnt, 8);
        chk("full_head_uid", rtr_uid, 8'h40);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrap_crt_rdy", crt_rdy, 1);
        chk("wrap_crt_idx", crt_idx, 0);
        chk("wrap_cnt", dcq_cnt, 7);
        chk("wrap_next_uid", rtr_uid, 8'h41);
        tick;

        // Simultaneous create and retire holds the count
        do_reset;
        create_n(3, 8'h50, 16'h0000);
        drive(1, 8'h53, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("simul_rtr_vld", rtr_vld, 1);
        chk("simul_cnt_pre", dcq_cnt, 3);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("simul_cnt_post", dcq_cnt, 3);
        chk("simul_next_uid", rtr_uid, 8'h51);
        chk("simul_idx", crt_idx, 4);
        tick;

        // Flush beats same-cycle create, dret and retire
        do_reset;
        create_n(5, 8'h60, 16'h0001);
        drive(1, 8'h70, 16'h0000, 0, 1, 0, 16'h0001, 1, 1);
        @(negedge clk);
        chk("flush_crt_rdy", crt_rdy, 0);
        chk("flush_rtr_vld", rtr_vld, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("flush_cnt", dcq_cnt, 0);
        chk("flush_empty", dcq_empty, 1);
        chk("flush_idx", crt_idx, 0);
        chk("flush_rtr", rtr_vld, 0);
        tick;

        // Asynchronous reset mid-operation
        do_reset;
        create_n(4, 8'h80, 16'h0001);
        drive(0, 0, 0, 0, 1, 0, 16'h0001, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_rst_rtr", rtr_vld, 1);
        chk("pre_rst_cnt", dcq_cnt, 4);
        #1;
        cpurst_b = 1'b0;
        #1;
        chk("arst_cnt", dcq_cnt, 0);
        chk("arst_empty", dcq_empty, 1);
        chk("arst_rdy", crt_rdy, 1);
        chk("arst_idx", crt_idx, 0);
        chk("arst_rtr", rtr_vld, 0);
        @(posedge clk);
        #1;
        cpurst_b = 1'b1;
        drive(0, 0, 0, 0, 1, 2, 16'hFFFF, 1, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        chk("post_rst_dret_rtr", rtr_vld, 0);
        chk("post_rst_dret_cnt", dcq_cnt, 0);
        tick;

        // Randomized traffic against a queue model
        do_reset;
        for (int c = 0; c < 3000; c++) begin
            logic        cv, dv, rr, fl, e_rtr, fire_c;
            logic [2:0]  di;
            logic [15:0] vm, dm;
            logic [7:0]  uid;
            ent_t        e;
            cv  = ($urandom_range(0, 9) < 6);
            uid = 8'($urandom);
            vm  = 16'($urandom) & 16'h0007;
            dv  = ($urandom_range(0, 9) < 6);
            if (q.size() > 0 && $urandom_range(0, 1) == 1)
                di = q[$urandom_range(0, q.size() - 1)].slot;
            else
                di = 3'($urandom);
            dm  = 16'($urandom) & 16'h0007;
            rr  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 49) == 0);
            drive(cv, uid, vm, 1'($urandom), dv, di, dm, rr, fl);

            e_rtr = (q.size() > 0) && (q[0].pend == 0) && !fl;
            @(negedge clk);
            chk("rnd_crt_rdy", crt_rdy, (q.size() < 8) && !fl);
            chk("rnd_crt_idx", crt_idx, mtail);
            chk("rnd_cnt", dcq_cnt, q.size());
            chk("rnd_empty", dcq_empty, q.size() == 0);
            chk("rnd_rtr_vld", rtr_vld, e_rtr);
            if (e_rtr) begin
                chk("rnd_rtr_uid", rtr_uid, q[0].uid);
                chk("rnd_rtr_vd", rtr_vdreg0_idx, q[0].vd);
                chk("rnd_rtr_wb", rtr_wb_vld, q[0].wb);
                chk("rnd_rtr_last", rtr_op_last, q[0].last);
            end
            tick;

            if (fl) begin
                q.delete();
                mtail = 0;
            end else begin
                fire_c = cv && (q.size() < 8);
                if (dv)
                    foreach (q[k])
                        if (q[k].slot == di) q[k].pend = q[k].pend & ~dm;
                if (e_rtr && rr) void'(q.pop_front());
                if (fire_c) begin
                    e.uid  = uid;
                    e.vd   = uid[4:0];
                    e.wb   = ~crt_no_wb;
                    e.last = uid[0];
                    e.pend = vm;
                    e.slot = 3'(mtail);
                    q.push_back(e);
                    mtail = (mtail + 1) % 8;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xpu_vpu_pc_tn_vlsu_dcq_array.md
XPU_VPU_PC_TN_VLSU_DCQ_ARRAY -- requirements
Module: xpu_vpu_pc_tn_vlsu_dcq_array

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entry count (power of two, 2..32).
REQ-002 SHALL have parameter UID_W, default 8, uop uid width.
REQ-003 SHALL have parameter ENUM, default 16, element-mask width per entry.
REQ-004 SHALL define PTR_W = log2(DEPTH) as a localparam.
REQ-005 SHALL have port dcq_entry_clk  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port cpurst_b  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port giu_xx_async_flush  in  1  synchronous flush of all entries.
REQ-008 SHALL have ports crt_vld in 1, crt_rdy out 1: create handshake.
REQ-009 SHALL have create payload ports crt_uid in UID_W, crt_vmask in ENUM, crt_no_wb in 1, crt_vdreg0_idx in 5, crt_op_last in 1.
REQ-010 SHALL have port crt_idx  out  PTR_W  slot index the create is written to (tail pointer).
REQ-011 SHALL have ports dret_vld in 1, dret_idx in PTR_W, dret_mask in ENUM: data-return event clearing pending elements.
REQ-012 SHALL have ports rtr_vld out 1, rtr_rdy in 1: in-order retire handshake.
REQ-013 SHALL have retire payload ports rtr_uid out UID_W, rtr_vdreg0_idx out 5, rtr_wb_vld out 1, rtr_op_last out 1.
REQ-014 SHALL have ports dcq_cnt out PTR_W+1 (occupancy) and dcq_empty out 1.

Function
REQ-015 SHALL keep per entry: vld, wb_vld, pending[ENUM-1:0], uid, vdreg0_idx, op_last; payload fields are non-reset flops.
REQ-016 SHALL have crt_rdy = (dcq_cnt < DEPTH) & ~giu_xx_async_flush, combinational, with no same-cycle retire bypass.
REQ-017 SHALL, on crt_vld & crt_rdy, write the tail slot: vld=1, wb_vld=~crt_no_wb, pending=crt_vmask, payload latched; tail advances by 1 modulo DEPTH.
REQ-018 SHALL, on dret_vld with vld[dret_idx]=1, set pending[dret_idx] &= ~dret_mask; a return to an invalid slot SHALL be ignored.
REQ-019 SHALL treat an entry as complete when vld=1 and pending==0; an entry created with crt_vmask=0 SHALL be complete from the next cycle.
REQ-020 SHALL drive rtr_vld = head entry complete & ~giu_xx_async_flush, combinationally; the rtr_* payload SHALL be the head entry fields.
REQ-021 SHALL hold rtr_vld and the payload stable until rtr_rdy; on rtr_vld & rtr_rdy it SHALL clear head vld/wb_vld, and head SHALL advance by 1 modulo DEPTH.
REQ-022 SHALL retire strictly in order: a complete non-head entry SHALL NOT be presented.
REQ-023 SHALL update dcq_cnt as +1 on create only, -1 on retire only, and unchanged on simultaneous create and retire.
REQ-024 SHALL have dcq_empty = (dcq_cnt == 0).
REQ-025 SHALL, when a dret_idx equal to the head slot and a retire occur in the same cycle, apply the retire; a dret completing the head SHALL make rtr_vld rise the following cycle (one-cycle latency).
REQ-026 SHALL, on giu_xx_async_flush, clear all vld and wb_vld, set head=tail=0 and dcq_cnt=0 next cycle, with priority over same-cycle create, dret and retire.

Reset
REQ-027 SHALL, while cpurst_b=0, clear all vld and wb_vld, set head=tail=0 and dcq_cnt=0, giving crt_rdy=1, crt_idx=0, rtr_vld=0, dcq_empty=1.
REQ-028 SHALL, on reset assertion mid-operation, discard all in-flight entries immediately (asynchronously), with no retire emitted.

Verification
REQ-029 SHALL be checked: DEPTH=8, create uid 0x11 vmask 0x000F no_wb=0; dret idx0 mask 0x0003, then 0x000C -> rtr_vld=1 one cycle after the second dret, rtr_uid=0x11, rtr_wb_vld=1.
REQ-030 SHALL be checked: 8 creates with rtr_rdy=0 -> dcq_cnt=8, crt_rdy=0; a 9th crt_vld SHALL be dropped; 1 retire -> crt_rdy=1, next crt_idx=0 (wrap).
REQ-031 SHALL be checked: slots 0,1 created, slot1 completed first -> rtr_vld=0 until slot0 completes; retire order uid0 then uid1.
REQ-032 SHALL be checked: create and retire in the same cycle at cnt=3 -> cnt stays 3; create vmask=0 no_wb=1 -> complete next cycle, rtr_wb_vld=0.
REQ-033 SHALL be checked: flush with cnt=5 plus same-cycle crt_vld and dret_vld -> next cycle cnt=0, dcq_empty=1, crt_idx=0, rtr_vld=0.
REQ-034 SHALL be checked: cpurst_b pulsed low with cnt=4 -> outputs at reset values asynchronously; dret to slot 2 after release SHALL be ignored.
